// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmitter and the future receiver
//
// Purpose: parity encodings, the frame FSM state type and the baud divider
// helper. Kept free of transmitter specifics so uart_rx can reuse it.
// Ports: none (package).

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per bit; truncating division.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead read and occupancy output
//
// Purpose: buffers words between a producer and a consumer in one clock
// domain. rd_data_o always presents the oldest entry while not empty.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, empties the FIFO
//   wr_en_i    write request, ignored when full
//   wr_data_i  write word
//   rd_en_i    read (pop) request, ignored when empty
//   rd_data_o  oldest word
//   full_o     no free entries
//   empty_o    no stored entries
//   level_o    number of stored entries

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) level_d = level_q + LW'(1);
    else if (do_rd && !do_wr) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - buffered UART transmitter with valid/ready word input
//
// Purpose: accepts words into a FIFO and sends them as back-to-back UART
// frames (start, DATA_BITS LSB first, optional parity, STOP_BITS stop).
// Ports:
//   sclk        system clock
//   s_rst       synchronous active-high reset
//   in_data     word to send
//   in_valid    in_data valid
//   in_ready    FIFO can accept a word
//   rs232_tx    registered serial line, idles high
//   busy        frame in progress or words pending
//   fifo_level  FIFO occupancy

module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sclk,
  input  logic                          s_rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          rs232_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 pop;
  logic                 bit_end;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (sclk),
    .rst_i     (s_rst),
    .wr_en_i   (in_valid),
    .wr_data_i (in_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign rs232_tx = tx_q;
  assign busy     = (state_q != ST_IDLE) || (fifo_level != '0);
  assign bit_end  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    // Counter restarts at every bit boundary, which covers every state entry.
    if (state_q == ST_IDLE || bit_end) baud_d = '0;
    else                               baud_d = baud_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          shift_d = fifo_rd_data;
          par_d   = (^fifo_rd_data) ^ PAR_INV;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next frame so there is no idle gap.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = ST_START;
              shift_d = fifo_rd_data;
              par_d   = (^fifo_rd_data) ^ PAR_INV;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so the output register
    // changes on the same edge as the state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb/tb_uart_tx_stream.sv - self-checking bench for uart_tx_stream

module tb_uart_tx_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld;
  logic [7:0] din [4];
  logic [3:0] rdy, txl, bsy;
  logic [2:0] lvl_w [4];

  int tests = 0;
  int fails = 0;

  // Per-instance frame configuration: 8N1, 8E1, 8O1, 7N2
  int db_c [4] = '{8, 8, 8, 7};
  int pb_c [4] = '{0, 2, 1, 0};
  int sb_c [4] = '{1, 1, 1, 2};

  logic [7:0] wq [8];

  always #5 clk = ~clk;

  uart_tx_stream #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .sclk(clk), .s_rst(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .rs232_tx(txl[0]), .busy(bsy[0]), .fifo_level(lvl_w[0]));

  uart_tx_stream #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .sclk(clk), .s_rst(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .rs232_tx(txl[1]), .busy(bsy[1]), .fifo_level(lvl_w[1]));

  uart_tx_stream #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .sclk(clk), .s_rst(rst), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .rs232_tx(txl[2]), .busy(bsy[2]), .fifo_level(lvl_w[2]));

  uart_tx_stream #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .sclk(clk), .s_rst(rst), .in_data(din[3][6:0]), .in_valid(vld[3]), .in_ready(rdy[3]),
    .rs232_tx(txl[3]), .busy(bsy[3]), .fifo_level(lvl_w[3]));

  task automatic chk(input string tag, input int idx, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s inst%0d t=%0t: observed %0h expected %0h", tag, idx, $time, obs, exp);
    end
  endtask

  function automatic int frame_bits(input int i);
    return 1 + db_c[i] + ((pb_c[i] != 0) ? 1 : 0) + sb_c[i];
  endfunction

  // Bit b of the frame carrying word w, straight from the frame format rules.
  function automatic logic frame_bit(input int i, input logic [7:0] w, input int b);
    int ones;
    ones = 0;
    for (int j = 0; j < db_c[i]; j++) ones += int'(w[j]);
    if (b == 0) return 1'b0;
    if (b <= db_c[i]) return w[b-1];
    if (pb_c[i] != 0 && b == db_c[i] + 1) return (pb_c[i] == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
    return 1'b1;
  endfunction

  task automatic check_idle(input int idx, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk("idle_tx", idx, int'(txl[idx]), 1);
      chk("idle_ready", idx, int'(rdy[idx]), 1);
      chk("idle_busy", idx, int'(bsy[idx]), 0);
      chk("idle_level", idx, int'(lvl_w[idx]), 0);
    end
  endtask

  // Pushes wq[0..n-1] into instance idx as fast as the handshake allows and
  // compares every cycle against an occupancy/timeline model: frames start one
  // edge after the first accept and then follow each other with no gap.
  task automatic run(input int idx, input int n, input int ncyc);
    int  acc, lvl, k, fl, off;
    bit  acc_now, st_now, exp_tx, in_frame;
    acc = 0; lvl = 0; k = -1;
    fl = frame_bits(idx) * 10;
    for (int e = 1; e <= ncyc; e++) begin
      vld[idx] = (acc < n);
      din[idx] = wq[(acc < n) ? acc : 0];
      @(posedge clk);
      st_now  = (k >= 0) && (e >= k + 1) && ((e - k - 1) % fl == 0) && ((e - k - 1) / fl < n);
      acc_now = vld[idx] && (lvl < 4);
      if (acc_now) begin
        if (k < 0) k = e;
        acc++;
      end
      lvl = lvl + int'(acc_now) - int'(st_now);
      @(negedge clk);
      off      = (k < 0) ? -1 : e - k - 1;
      in_frame = (off >= 0) && (off < n * fl);
      exp_tx   = in_frame ? frame_bit(idx, wq[off / fl], (off % fl) / 10) : 1'b1;
      chk("tx", idx, int'(txl[idx]), int'(exp_tx));
      chk("ready", idx, int'(rdy[idx]), int'(lvl < 4));
      chk("busy", idx, int'(bsy[idx]), int'(in_frame || lvl != 0));
      chk("level", idx, int'(lvl_w[idx]), lvl);
    end
    vld[idx] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    vld = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) check_idle(i, (i == 0) ? 50 : 2);

    // 8N1 single word 0x55, then random words
    wq[0] = 8'h55;
    run(0, 1, 112);
    for (int j = 0; j < 3; j++) wq[j] = 8'($urandom);
    run(0, 3, 312);

    // Parity: 0x07 even -> 1, odd -> 0, then random words on each
    wq[0] = 8'h07;
    run(1, 1, 122);
    run(2, 1, 122);
    for (int j = 0; j < 3; j++) wq[j] = 8'($urandom);
    run(1, 3, 342);
    for (int j = 0; j < 3; j++) wq[j] = 8'($urandom);
    run(2, 3, 342);

    // Six words into a depth-4 FIFO with valid held high
    for (int j = 0; j < 6; j++) wq[j] = 8'hA0 + 8'(j);
    run(0, 6, 612);
    for (int j = 0; j < 6; j++) wq[j] = 8'($urandom);
    run(1, 6, 672);

    // Reset pulse during data bit 3 of the first of two queued frames
    wq[0] = 8'($urandom);
    wq[1] = 8'($urandom);
    run(0, 2, 45);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", 0, int'(txl[0]), 1);
    chk("rst_level", 0, int'(lvl_w[0]), 0);
    chk("rst_busy", 0, int'(bsy[0]), 0);
    check_idle(0, 50);

    // 7 data bits, 2 stop bits: 0x41 then random words
    wq[0] = 8'h41;
    run(3, 1, 122);
    for (int j = 0; j < 3; j++) wq[j] = 8'($urandom) & 8'h7F;
    run(3, 3, 342);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
